// File: rtl/mmio_blocking_responder_if.sv
// Bus bundle between the core's blocking load/store queues and the MMIO responder.
// The master modport is the core side; the slave modport is the responder side.
interface mmio_blocking_responder_if;
    logic        load_empty_in;
    logic [31:0] load_addr_in;
    logic        load_rden_out;
    logic        load_rdy_in;
    logic        load_valid_out;
    logic [31:0] load_result_out;
    logic        store_empty_in;
    logic [31:0] store_addr_in;
    logic [31:0] store_value_in;
    logic        store_rden_out;

    modport master (
        output load_empty_in, load_addr_in, load_rdy_in,
        output store_empty_in, store_addr_in, store_value_in,
        input  load_rden_out, load_valid_out, load_result_out, store_rden_out
    );

    modport slave (
        input  load_empty_in, load_addr_in, load_rdy_in,
        input  store_empty_in, store_addr_in, store_value_in,
        output load_rden_out, load_valid_out, load_result_out, store_rden_out
    );
endinterface

// File: rtl/mmio_blocking_responder.sv
// MMIO responder for the core's blocking load/store queues: ID, cycle counter, doorbell and scratch registers.
// Define MMIO_RESPONDER_STATS_EN to add load/store/bad-access counters at BASE_ADDR+0x100..0x108.
module mmio_blocking_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          NUM_REGS     = 16,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] ID_VALUE     = 32'h4B41_4E41
) (
    input  logic                       clk,
    input  logic                       rst,
    mmio_blocking_responder_if.slave   bus,
    output logic                       doorbell_out
);

    localparam int          IDX_W         = $clog2(NUM_REGS);
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [31:0] result_q, result_d;
    logic [31:0] cycle_q, cycle_d;
    logic        doorbell_q, doorbell_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    logic        store_pop;
    logic        load_pop;
    logic        load_valid;
    logic        load_hit;
    logic        load_bad;
    logic        store_writable;
    logic [31:0] load_off;
    logic [31:0] store_off;
    logic [31:0] load_data;

    function automatic logic [31:0] word_offset(input logic [31:0] addr);
        return (addr - BASE_ADDR) >> 2;
    endfunction

    // The addr >= BASE_ADDR term keeps addresses below the bank from wrapping into it.
    function automatic logic is_mapped(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) &&
               (word_offset(addr) < 32'(NUM_REGS));
    endfunction

`ifdef MMIO_RESPONDER_STATS_EN
    localparam logic [31:0] STAT_LOADS_ADDR  = BASE_ADDR + 32'h100;
    localparam logic [31:0] STAT_STORES_ADDR = BASE_ADDR + 32'h104;
    localparam logic [31:0] STAT_BAD_ADDR    = BASE_ADDR + 32'h108;

    logic [31:0] stat_loads_q, stat_loads_d;
    logic [31:0] stat_stores_q, stat_stores_d;
    logic [31:0] stat_bad_q, stat_bad_d;
    logic        load_is_stat;
`endif

    always_comb begin
        load_off       = word_offset(bus.load_addr_in);
        store_off      = word_offset(bus.store_addr_in);
        load_hit       = is_mapped(bus.load_addr_in);
        store_writable = is_mapped(bus.store_addr_in) && (store_off >= 32'd2);
        load_data      = UNMAPPED_DATA;
        if (load_hit) begin
            if (load_off == 32'd0) begin
                load_data = ID_VALUE;
            end else if (load_off == 32'd1) begin
                load_data = cycle_q;
            end else begin
                load_data = regs_q[load_off[IDX_W-1:0]];
            end
        end
`ifdef MMIO_RESPONDER_STATS_EN
        // Counters report their value before the current pop is counted.
        load_is_stat = 1'b1;
        if (bus.load_addr_in == STAT_LOADS_ADDR) begin
            load_data = stat_loads_q;
        end else if (bus.load_addr_in == STAT_STORES_ADDR) begin
            load_data = stat_stores_q;
        end else if (bus.load_addr_in == STAT_BAD_ADDR) begin
            load_data = stat_bad_q;
        end else begin
            load_is_stat = 1'b0;
        end
        load_bad = !load_hit && !load_is_stat;
`else
        load_bad = !load_hit;
`endif
    end

    // Pops are gated while reset is held so every output reads 0 during reset.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        result_d   = result_q;
        store_pop  = 1'b0;
        load_pop   = 1'b0;
        load_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst) begin
                    if (!bus.store_empty_in) begin
                        store_pop = 1'b1;
                    end else if (!bus.load_empty_in) begin
                        load_pop = 1'b1;
                        result_d = load_data;
                        wait_d   = 3'd1;
                        state_d  = (READ_LATENCY > 1) ? WAIT : RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_q == 3'(READ_LATENCY - 1)) begin
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            RESP: begin
                load_valid = bus.load_rdy_in;
                if (bus.load_rdy_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        doorbell_d = store_pop && store_writable && (store_off == 32'd2);
        regs_d     = regs_q;
        if (store_pop && store_writable) begin
            regs_d[store_off[IDX_W-1:0]] = bus.store_value_in;
        end
    end

`ifdef MMIO_RESPONDER_STATS_EN
    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_bad_d    = stat_bad_q;
        if (load_pop) begin
            stat_loads_d = stat_loads_q + 32'd1;
        end
        if (store_pop) begin
            stat_stores_d = stat_stores_q + 32'd1;
        end
        if ((load_pop && load_bad) || (store_pop && !store_writable)) begin
            stat_bad_d = stat_bad_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_bad_q    <= '0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_bad_q    <= stat_bad_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            result_q   <= '0;
            cycle_q    <= '0;
            doorbell_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            result_q   <= result_d;
            cycle_q    <= cycle_d;
            doorbell_q <= doorbell_d;
            regs_q     <= regs_d;
        end
    end

    assign bus.load_rden_out   = load_pop;
    assign bus.store_rden_out  = store_pop;
    assign bus.load_valid_out  = load_valid;
    assign bus.load_result_out = result_q;
    assign doorbell_out        = doorbell_q;

endmodule

// File: tb/tb_mmio_blocking_responder.sv
// Directed bench for mmio_blocking_responder, built with READ_LATENCY=3 so the WAIT state is exercised.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mmio_blocking_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] ID    = 32'h4B41_4E41;
    localparam logic [31:0] BEEF  = 32'hDEAD_BEEF;
    localparam int          RL    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        doorbell;
    logic [31:0] tb_cycles;
    int          tests_run = 0;
    int          tests_failed = 0;

    mmio_blocking_responder_if bus ();

    mmio_blocking_responder #(
        .BASE_ADDR   (BASE),
        .NUM_REGS    (16),
        .READ_LATENCY(RL),
        .ID_VALUE    (ID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .doorbell_out(doorbell)
    );

    always #5 clk = ~clk;

    // Reference cycle count: zero while reset is held, +1 on every edge after release.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cycles <= '0;
        else      tb_cycles <= tb_cycles + 32'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic load_empty, input logic [31:0] load_addr,
                                 input logic store_empty, input logic [31:0] store_addr,
                                 input logic [31:0] store_value);
        bus.load_empty_in  = load_empty;
        bus.load_addr_in   = load_addr;
        bus.store_empty_in = store_empty;
        bus.store_addr_in  = store_addr;
        bus.store_value_in = store_value;
    endtask

    // Load already presented with load_rdy_in=1: check pop now, valid exactly RL cycles later.
    task automatic finishLoad(input string tag, input logic [31:0] expected, input logic use_counter);
        logic [31:0] exp_val;
        exp_val = expected;
        @(negedge clk);
        checkOutput({tag, " pop"}, 32'(bus.load_rden_out), 32'd1);
        if (use_counter) exp_val = tb_cycles;
        nextCycle();
        bus.load_empty_in = 1'b1;
        for (int i = 1; i < RL; i++) begin
            @(negedge clk);
            checkOutput({tag, " early valid"}, 32'(bus.load_valid_out), 32'd0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput({tag, " valid"}, 32'(bus.load_valid_out), 32'd1);
        checkOutput({tag, " data"}, bus.load_result_out, exp_val);
        nextCycle();
    endtask

    task automatic runLoad(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b0, addr, 1'b1, 32'd0, 32'd0);
        bus.load_rdy_in = 1'b1;
        finishLoad(tag, expected, 1'b0);
    endtask

    task automatic runStore(input string tag, input logic [31:0] addr, input logic [31:0] value);
        applyStimulus(1'b1, 32'd0, 1'b0, addr, value);
        @(negedge clk);
        checkOutput({tag, " store pop"}, 32'(bus.store_rden_out), 32'd1);
        checkOutput({tag, " no load pop"}, 32'(bus.load_rden_out), 32'd0);
        nextCycle();
        bus.store_empty_in = 1'b1;
    endtask

    initial begin
        applyStimulus(1'b1, 32'd0, 1'b1, 32'd0, 32'd0);
        bus.load_rdy_in = 1'b0;

        // Reset state, with both queues non-empty to show nothing pops while reset is held
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, BASE, 1'b0, BASE + 32'h8, 32'h1);
        @(negedge clk);
        checkOutput("reset store_rden", 32'(bus.store_rden_out), 32'd0);
        checkOutput("reset load_rden", 32'(bus.load_rden_out), 32'd0);
        checkOutput("reset valid", 32'(bus.load_valid_out), 32'd0);
        checkOutput("reset result", bus.load_result_out, 32'd0);
        checkOutput("reset doorbell", 32'(doorbell), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 32'd0, 1'b1, 32'd0, 32'd0);
        rst = 1'b1;

        runLoad("id", BASE, ID);

        applyStimulus(1'b0, BASE + 32'h4, 1'b1, 32'd0, 32'd0);
        bus.load_rdy_in = 1'b1;
        finishLoad("cycle counter", 32'd0, 1'b1);

        // Store and load to the same address queued together: store wins
        applyStimulus(1'b0, BASE + 32'hC, 1'b0, BASE + 32'hC, 32'h1234_5678);
        bus.load_rdy_in = 1'b1;
        @(negedge clk);
        checkOutput("raw store first", 32'(bus.store_rden_out), 32'd1);
        checkOutput("raw load held", 32'(bus.load_rden_out), 32'd0);
        nextCycle();
        bus.store_empty_in = 1'b1;
        checkOutput("raw no doorbell", 32'(doorbell), 32'd0);
        finishLoad("raw", 32'h1234_5678, 1'b0);

        runLoad("past end", BASE + 32'h40, BEEF);
        runLoad("misaligned", BASE + 32'h2, BEEF);
        runLoad("below base", BASE - 32'h4, BEEF);
        runStore("id store", BASE, 32'hFFFF_FFFF);
        runLoad("id read-only", BASE, ID);
        runStore("last reg", BASE + 32'h3C, 32'hCAFE_F00D);
        runLoad("last reg", BASE + 32'h3C, 32'hCAFE_F00D);

        runStore("doorbell", BASE + 32'h8, 32'hA5A5_0001);
        checkOutput("doorbell pulse", 32'(doorbell), 32'd1);
        nextCycle();
        checkOutput("doorbell drop", 32'(doorbell), 32'd0);
        runLoad("doorbell readback", BASE + 32'h8, 32'hA5A5_0001);

        // Back-to-back stores pop on consecutive cycles
        applyStimulus(1'b1, 32'd0, 1'b0, BASE + 32'h10, 32'h1111_0010);
        @(negedge clk);
        checkOutput("burst store 0", 32'(bus.store_rden_out), 32'd1);
        nextCycle();
        bus.store_addr_in  = BASE + 32'h14;
        bus.store_value_in = 32'h2222_0014;
        @(negedge clk);
        checkOutput("burst store 1", 32'(bus.store_rden_out), 32'd1);
        nextCycle();
        bus.store_empty_in = 1'b1;

        // Stalled response with more work queued behind it
        applyStimulus(1'b0, BASE + 32'h10, 1'b1, 32'd0, 32'd0);
        bus.load_rdy_in = 1'b0;
        @(negedge clk);
        checkOutput("stall pop", 32'(bus.load_rden_out), 32'd1);
        nextCycle();
        applyStimulus(1'b0, BASE + 32'h14, 1'b0, BASE + 32'h18, 32'h3333_0018);
        for (int i = 0; i < RL - 1 + 5; i++) begin
            @(negedge clk);
            checkOutput("stall valid", 32'(bus.load_valid_out), 32'd0);
            checkOutput("stall pops", 32'(bus.load_rden_out | bus.store_rden_out), 32'd0);
            checkOutput("stall result", bus.load_result_out, 32'h1111_0010);
            nextCycle();
        end
        bus.load_rdy_in = 1'b1;
        @(negedge clk);
        checkOutput("stall release valid", 32'(bus.load_valid_out), 32'd1);
        checkOutput("stall release data", bus.load_result_out, 32'h1111_0010);
        nextCycle();
        @(negedge clk);
        checkOutput("after stall store", 32'(bus.store_rden_out), 32'd1);
        checkOutput("after stall load held", 32'(bus.load_rden_out), 32'd0);
        nextCycle();
        bus.store_empty_in = 1'b1;
        finishLoad("queued load", 32'h2222_0014, 1'b0);
        runLoad("queued store readback", BASE + 32'h18, 32'h3333_0018);

        // Reset while a load sits in WAIT: the response must never appear
        applyStimulus(1'b0, BASE + 32'hC, 1'b1, 32'd0, 32'd0);
        bus.load_rdy_in = 1'b1;
        @(negedge clk);
        checkOutput("wait-reset pop", 32'(bus.load_rden_out), 32'd1);
        nextCycle();
        bus.load_empty_in = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("wait-reset valid", 32'(bus.load_valid_out), 32'd0);
        checkOutput("wait-reset result", bus.load_result_out, 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        for (int i = 0; i < RL + 3; i++) begin
            @(negedge clk);
            checkOutput("post-reset valid", 32'(bus.load_valid_out), 32'd0);
            nextCycle();
        end

        runLoad("scratch cleared", BASE + 32'hC, 32'd0);
        runLoad("scratch cleared 2", BASE + 32'h10, 32'd0);
        runLoad("unmapped", BASE + 32'h40, BEEF);
        runStore("stats store 0", BASE + 32'hC, 32'h0000_000C);
        runStore("stats store 1", BASE + 32'h10, 32'h0000_0010);
        runStore("stats store 2", BASE + 32'h8, 32'h0000_0008);
`ifdef MMIO_RESPONDER_STATS_EN
        runLoad("stat loads", BASE + 32'h100, 32'd3);
        runLoad("stat stores", BASE + 32'h104, 32'd3);
        runLoad("stat bad", BASE + 32'h108, 32'd1);
`else
        runLoad("no stats 0x100", BASE + 32'h100, BEEF);
        runLoad("no stats 0x108", BASE + 32'h108, BEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
